// File: rtl/arith_csr_unit.sv
// -----------------------------------------------------------------------------
// arith_csr_unit
//   Register-mapped arithmetic coprocessor. The host loads operands and an
//   opcode through a small CSR bank, pulses CTRL.START, then polls
//   STATUS.BUSY/DONE or waits for irq_o. Single-step ops (ADD/SUB/AND/XOR)
//   finish one cycle after START. MUL (shift-add) and the optional DIV
//   (restoring) take DATA_W cycles.
//
//   Parameters
//     DATA_W  operand width, 2..32; results span RES_LO/RES_HI (2*DATA_W)
//     ADDR_W  CSR address width (>= 3); 2**ADDR_W registers
//
//   Ports
//     clk_i    rising-edge clock
//     rst_ni   asynchronous active-low reset
//     wr_en_i  write strobe; data_i is written to CSR addr_i at the edge
//     addr_i   CSR address for both read and write
//     data_i   32-bit write data
//     data_o   registered read data of CSR addr_i (1-cycle latency)
//     irq_o    STATUS.DONE & CTRL.IRQ_EN
//
//   CSR map
//     0 OPD1  RW    1 OPD2  RW
//     2 CTRL  RW    [0] START (write-1 pulse, reads 0), [3:1] OP, [4] IRQ_EN
//     3 STATUS RO   [0] BUSY, [1] DONE (W1C), [2] ERR (W1C)
//     4 RES_LO RO   5 RES_HI RO
//     6.. 32-bit scratch registers
//
//   Bus handshake: there is no valid/ready pair. A write is accepted on every
//   edge where wr_en_i is high. A read is always enabled, and data_o shows
//   the value addr_i selected before that edge, so a same-cycle write is not
//   visible until the following read.
//
//   Build option
//     ARITH_CSR_DIV_EN  enables OP 4 = DIV. Without it, OP 4 is rejected as
//                       illegal and no divider logic is built.
// -----------------------------------------------------------------------------
module arith_csr_unit #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  output logic              irq_o
);

  localparam int NREG  = 2 ** ADDR_W;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [ADDR_W-1:0] A_OPD1   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_OPD2   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_RES_LO = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_RES_HI = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_SCR0   = ADDR_W'(6);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
`ifdef ARITH_CSR_DIV_EN
  localparam logic [2:0] OP_DIV = 3'd4;
`endif
  localparam logic [2:0] OP_MUL = 3'd6;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t            state;
  logic [DATA_W-1:0] opd1, opd2;
  logic [2:0]        ctrl_op;
  logic              ctrl_irq_en;
  logic              done, err;
  logic [DATA_W-1:0] res_lo, res_hi;
  logic [31:0]       scratch [NREG];

  // Working copies used by the in-flight op. w_lo starts as OPD1 and w_a
  // holds OPD2. For MUL/DIV, {w_hi, w_lo} is the shifting accumulator.
  logic [2:0]        w_op;
  logic [DATA_W-1:0] w_a, w_hi, w_lo;
  logic [CNT_W-1:0]  cnt;

  function automatic logic op_legal(input logic [2:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_MUL: op_legal = 1'b1;
`ifdef ARITH_CSR_DIV_EN
      OP_DIV:                                 op_legal = 1'b1;
`endif
      default:                                op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic op_multi(input logic [2:0] op);
`ifdef ARITH_CSR_DIV_EN
    op_multi = (op == OP_MUL) || (op == OP_DIV);
`else
    op_multi = (op == OP_MUL);
`endif
  endfunction

  // ---------------------------------------------------------------- decode
  logic busy, start_req, start_ok, start_err, last_step;
  logic done_clr, err_clr, div_zero;

  assign busy      = (state == S_RUN);
  assign start_req = wr_en_i && (addr_i == A_CTRL) && data_i[0];
  assign start_ok  = start_req && !busy && op_legal(data_i[3:1]);
  assign start_err = start_req && !start_ok;
  assign last_step = busy && (cnt == '0);
  assign done_clr  = wr_en_i && (addr_i == A_STATUS) && data_i[1];
  assign err_clr   = wr_en_i && (addr_i == A_STATUS) && data_i[2];

  // ------------------------------------------------------ datapath step
  logic [DATA_W:0]   add_full;
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W-1:0] step_hi, step_lo;
  logic [DATA_W-1:0] fin_lo, fin_hi;
`ifdef ARITH_CSR_DIV_EN
  logic [DATA_W:0]   rem_sh;
  logic              div_ge;
`endif

  always_comb begin
    add_full = {1'b0, w_lo} + {1'b0, w_a};
    // Shift-add multiply: conditionally add the multiplicand into the high
    // half, then shift the whole {carry, hi, lo} right by one.
    mul_sum  = {1'b0, w_hi} + (w_lo[0] ? {1'b0, w_a} : '0);
    step_hi  = mul_sum[DATA_W:1];
    step_lo  = {mul_sum[0], w_lo[DATA_W-1:1]};
    div_zero = 1'b0;
`ifdef ARITH_CSR_DIV_EN
    // Restoring divide: shift the next dividend bit into the remainder and
    // subtract the divisor when it fits. A zero divisor always fits, which
    // yields quotient all ones and remainder OPD1 without special casing.
    rem_sh = {w_hi, w_lo[DATA_W-1]};
    div_ge = (rem_sh >= {1'b0, w_a});
    if (w_op == OP_DIV) begin
      step_hi  = div_ge ? DATA_W'(rem_sh - {1'b0, w_a}) : rem_sh[DATA_W-1:0];
      step_lo  = {w_lo[DATA_W-2:0], div_ge};
      div_zero = (w_a == '0);
    end
`endif
    fin_lo = '0;
    fin_hi = '0;
    case (w_op)
      OP_ADD: begin
        fin_lo = add_full[DATA_W-1:0];
        fin_hi = DATA_W'(add_full[DATA_W]);
      end
      OP_SUB: begin
        fin_lo = w_lo - w_a;
        fin_hi = DATA_W'(w_lo < w_a);
      end
      OP_AND: fin_lo = w_lo & w_a;
      OP_XOR: fin_lo = w_lo ^ w_a;
`ifdef ARITH_CSR_DIV_EN
      OP_DIV: begin
        fin_lo = step_lo;
        fin_hi = step_hi;
      end
`endif
      OP_MUL: begin
        fin_lo = step_lo;
        fin_hi = step_hi;
      end
      default: begin
        fin_lo = '0;
        fin_hi = '0;
      end
    endcase
  end

  // ------------------------------------------------------------ read mux
  logic [31:0] rd_val;

  always_comb begin
    rd_val = '0;
    case (addr_i)
      A_OPD1:   rd_val = 32'(opd1);
      A_OPD2:   rd_val = 32'(opd2);
      A_CTRL:   rd_val = {27'd0, ctrl_irq_en, ctrl_op, 1'b0};
      A_STATUS: rd_val = {29'd0, err, done, busy};
      A_RES_LO: rd_val = 32'(res_lo);
      A_RES_HI: rd_val = 32'(res_hi);
      default:  if (addr_i >= A_SCR0) rd_val = scratch[addr_i];
    endcase
  end

  assign irq_o = done & ctrl_irq_en;

  // ------------------------------------------------- state and registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      opd1        <= '0;
      opd2        <= '0;
      ctrl_op     <= '0;
      ctrl_irq_en <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      res_lo      <= '0;
      res_hi      <= '0;
      w_op        <= '0;
      w_a         <= '0;
      w_hi        <= '0;
      w_lo        <= '0;
      cnt         <= '0;
      data_o      <= '0;
      for (int i = 0; i < NREG; i++) scratch[i] <= '0;
    end else begin
      data_o <= rd_val;

      if (wr_en_i) begin
        case (addr_i)
          A_OPD1: opd1 <= data_i[DATA_W-1:0];
          A_OPD2: opd2 <= data_i[DATA_W-1:0];
          A_CTRL: begin
            ctrl_op     <= data_i[3:1];
            ctrl_irq_en <= data_i[4];
          end
          default: if (addr_i >= A_SCR0) scratch[addr_i] <= data_i;
        endcase
      end

      case (state)
        S_IDLE: begin
          if (start_ok) begin
            state <= S_RUN;
            w_op  <= data_i[3:1];
            w_a   <= opd2;
            w_lo  <= opd1;
            w_hi  <= '0;
            cnt   <= op_multi(data_i[3:1]) ? CNT_W'(DATA_W - 1) : '0;
          end
        end
        S_RUN: begin
          w_hi <= step_hi;
          w_lo <= step_lo;
          if (cnt == '0) begin
            res_lo <= fin_lo;
            res_hi <= fin_hi;
            state  <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      // A completing op sets DONE even if software clears it on the same edge.
      if (last_step)                done <= 1'b1;
      else if (done_clr || start_ok) done <= 1'b0;

      if (start_err || (last_step && div_zero)) err <= 1'b1;
      else if (err_clr)                         err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arith_csr_unit.sv
module tb_arith_csr_unit;

  localparam logic [3:0] A_OPD1   = 4'd0;
  localparam logic [3:0] A_OPD2   = 4'd1;
  localparam logic [3:0] A_CTRL   = 4'd2;
  localparam logic [3:0] A_STATUS = 4'd3;
  localparam logic [3:0] A_RES_LO = 4'd4;
  localparam logic [3:0] A_RES_HI = 4'd5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] data_o;
  logic        irq_o;

  int checks = 0;
  int passes = 0;
  logic [31:0] exp_q[$];

  arith_csr_unit #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .wr_en_i(wr_en),
    .addr_i (addr),
    .data_i (wdata),
    .data_o (data_o),
    .irq_o  (irq_o)
  );

  // ------------------------------------------------------ clock / reset
  always #5 clk = ~clk;

  // ------------------------------------------------------------ drivers
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b0; addr = a;
    @(posedge clk); #1;
    d = data_o;
  endtask

  // Counts consecutive STATUS reads with BUSY set; 100 means it never cleared.
  task automatic wait_idle(output int n);
    logic [31:0] s;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      bus_read(A_STATUS, s);
      if (!s[0]) break;
      n++;
    end
  endtask

  // Reference result {RES_HI, RES_LO} for DATA_W = 8.
  function automatic logic [15:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] d;
    d = a - b;
    case (op)
      3'd0: model = 16'(a) + 16'(b);
      3'd1: model = {7'd0, (a < b), d};
      3'd2: model = {8'd0, a & b};
      3'd3: model = {8'd0, a ^ b};
      3'd4: model = (b == 8'd0) ? {a, 8'hFF} : {8'(a % b), 8'(a / b)};
      3'd6: model = 16'(a) * 16'(b);
      default: model = 16'd0;
    endcase
  endfunction

  // -------------------------------------------------------------- tests
  task automatic test_reset();
    logic [31:0] got, exp;
    #3;
    checks++;
    if (data_o !== 32'd0) $display("FAIL reset_data_o got 0x%0h exp 0x0", data_o); else passes++;
    checks++;
    if (irq_o !== 1'b0) $display("FAIL reset_irq got %0b exp 0", irq_o); else passes++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(32'd0);
      bus_read(4'(i), got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) $display("FAIL reset_read addr %0d got 0x%0h exp 0x%0h", i, got, exp); else passes++;
    end
  endtask

  task automatic test_add();
    logic [31:0] got, exp;
    logic [3:0]  ra [3];
    logic [31:0] re [3];
    int n;
    bus_write(A_OPD1, 32'd200);
    bus_write(A_OPD2, 32'd100);
    bus_write(A_CTRL, 32'h01);
    wait_idle(n);
    checks++;
    if (n != 1) $display("FAIL add_busy_cycles got %0d exp 1", n); else passes++;
    ra = '{A_RES_LO, A_RES_HI, A_STATUS};
    re = '{32'd44, 32'd1, 32'h2};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(re[i]);
      bus_read(ra[i], got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) $display("FAIL add_read addr %0d got 0x%0h exp 0x%0h", ra[i], got, exp); else passes++;
    end
  endtask

  task automatic test_mul();
    logic [31:0] got, exp;
    logic [3:0]  ra [3];
    logic [31:0] re [3];
    int n;
    bus_write(A_OPD1, 32'd255);
    bus_write(A_OPD2, 32'd255);
    bus_write(A_CTRL, 32'h0D);
    wait_idle(n);
    checks++;
    if (n != 8) $display("FAIL mul_busy_cycles got %0d exp 8", n); else passes++;
    ra = '{A_RES_LO, A_RES_HI, A_STATUS};
    re = '{32'h01, 32'hFE, 32'h2};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(re[i]);
      bus_read(ra[i], got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) $display("FAIL mul_read addr %0d got 0x%0h exp 0x%0h", ra[i], got, exp); else passes++;
    end
  endtask

  task automatic test_busy_err();
    logic [31:0] got, exp;
    logic [3:0]  ra [7];
    logic [31:0] re [7];
    int n;
    bus_write(A_OPD1, 32'd255);
    bus_write(A_OPD2, 32'd255);
    bus_write(A_CTRL, 32'h0D);   // MUL start
    bus_write(A_CTRL, 32'h03);   // SUB start while busy: rejected
    bus_write(A_OPD1, 32'd3);    // stored, but the running MUL keeps 255
    wait_idle(n);
    checks++;
    if (n != 6) $display("FAIL busy_err_remaining_busy got %0d exp 6", n); else passes++;
    ra = '{A_RES_LO, A_RES_HI, A_STATUS, A_OPD1, A_CTRL, A_STATUS, A_STATUS};
    re = '{32'h01, 32'hFE, 32'h6, 32'd3, 32'h02, 32'h2, 32'h2};
    for (int i = 0; i < 7; i++) begin
      if (i == 5) bus_write(A_STATUS, 32'h4);
      exp_q.push_back(re[i]);
      bus_read(ra[i], got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) $display("FAIL busy_err_read[%0d] addr %0d got 0x%0h exp 0x%0h", i, ra[i], got, exp); else passes++;
    end
  endtask

  task automatic test_illegal_op();
    logic [31:0] got, exp;
    logic [31:0] ctl [2];
    ctl = '{32'h0B, 32'h0F};     // OP 5 and OP 7 with START
    for (int k = 0; k < 2; k++) begin
      bus_write(A_CTRL, ctl[k]);
      for (int r = 0; r < 2; r++) begin
        // DONE from the previous run must survive the rejected START.
        exp_q.push_back(k == 0 ? 32'h6 : 32'h4);
        bus_read(A_STATUS, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) $display("FAIL illegal_status ctrl 0x%0h got 0x%0h exp 0x%0h", ctl[k], got, exp); else passes++;
      end
      bus_write(A_STATUS, 32'h6);
    end
  endtask

  task automatic test_div();
    logic [31:0] got, exp;
    int n;
`ifdef ARITH_CSR_DIV_EN
    logic [7:0]  divisor [2];
    logic [15:0] r;
    divisor = '{8'd7, 8'd0};
    for (int k = 0; k < 2; k++) begin
      bus_write(A_OPD1, 32'd100);
      bus_write(A_OPD2, 32'(divisor[k]));
      bus_write(A_CTRL, 32'h09);
      r = model(3'd4, 8'd100, divisor[k]);
      exp_q.push_back(32'(r[7:0]));
      exp_q.push_back(32'(r[15:8]));
      exp_q.push_back(divisor[k] == 8'd0 ? 32'h6 : 32'h2);
      wait_idle(n);
      checks++;
      if (n != 8) $display("FAIL div_busy_cycles got %0d exp 8", n); else passes++;
      bus_read(A_RES_LO, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) $display("FAIL div_res_lo by %0d got 0x%0h exp 0x%0h", divisor[k], got, exp); else passes++;
      bus_read(A_RES_HI, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) $display("FAIL div_res_hi by %0d got 0x%0h exp 0x%0h", divisor[k], got, exp); else passes++;
      bus_read(A_STATUS, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) $display("FAIL div_status by %0d got 0x%0h exp 0x%0h", divisor[k], got, exp); else passes++;
      bus_write(A_STATUS, 32'h6);
    end
`else
    bus_write(A_CTRL, 32'h09);
    wait_idle(n);
    checks++;
    if (n != 0) $display("FAIL nodiv_busy got %0d exp 0", n); else passes++;
    exp_q.push_back(32'h4);
    bus_read(A_STATUS, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) $display("FAIL nodiv_status got 0x%0h exp 0x%0h", got, exp); else passes++;
    bus_write(A_STATUS, 32'h4);
`endif
  endtask

  task automatic test_irq();
    int n;
    bus_write(A_OPD1, 32'd1);
    bus_write(A_OPD2, 32'd2);
    bus_write(A_CTRL, 32'h01);   // ADD without IRQ_EN
    wait_idle(n);
    checks++;
    if (irq_o !== 1'b0) $display("FAIL irq_disabled got %0b exp 0", irq_o); else passes++;
    bus_write(A_CTRL, 32'h10);   // enable IRQ while DONE is already set
    checks++;
    if (irq_o !== 1'b1) $display("FAIL irq_enable got %0b exp 1", irq_o); else passes++;
    bus_write(A_CTRL, 32'h11);   // START clears DONE
    checks++;
    if (irq_o !== 1'b0) $display("FAIL irq_start_clears got %0b exp 0", irq_o); else passes++;
    wait_idle(n);
    checks++;
    if (irq_o !== 1'b1) $display("FAIL irq_after_done got %0b exp 1", irq_o); else passes++;
    bus_write(A_STATUS, 32'h2);
    checks++;
    if (irq_o !== 1'b0) $display("FAIL irq_w1c got %0b exp 0", irq_o); else passes++;
  endtask

  task automatic test_scratch();
    logic [31:0] got, exp, val [16], nv;
    bus_write(A_RES_LO, 32'hAA);
    bus_write(A_RES_HI, 32'h55);
    exp_q.push_back(32'd3);      // 1 + 2 from the IRQ test
    bus_read(A_RES_LO, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) $display("FAIL res_lo_write_ignored got 0x%0h exp 0x%0h", got, exp); else passes++;
    exp_q.push_back(32'd0);
    bus_read(A_RES_HI, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) $display("FAIL res_hi_write_ignored got 0x%0h exp 0x%0h", got, exp); else passes++;
    for (int i = 6; i < 16; i++) begin
      val[i] = $urandom;
      bus_write(4'(i), val[i]);
    end
    for (int i = 6; i < 16; i++) begin
      exp_q.push_back(val[i]);
      bus_read(4'(i), got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) $display("FAIL scratch addr %0d got 0x%0h exp 0x%0h", i, got, exp); else passes++;
    end
    // Read and write of the same address on one edge returns the old value.
    nv = ~val[6];
    exp_q.push_back(val[6]);
    exp_q.push_back(nv);
    @(negedge clk);
    wr_en = 1'b1; addr = 4'd6; wdata = nv;
    @(posedge clk); #1;
    wr_en = 1'b0;
    got = data_o;
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) $display("FAIL rw_same_cycle got 0x%0h exp 0x%0h", got, exp); else passes++;
    bus_read(4'd6, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) $display("FAIL rw_after_write got 0x%0h exp 0x%0h", got, exp); else passes++;
  endtask

  task automatic test_random_ops();
    logic [31:0] got, exp;
    logic [2:0]  ops [$];
    logic [2:0]  op;
    logic [7:0]  a, b;
    logic [15:0] r;
    int n;
    ops = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
`ifdef ARITH_CSR_DIV_EN
    ops.push_back(3'd4);
`endif
    for (int t = 0; t < 14; t++) begin
      op = ops[$urandom_range(0, ops.size() - 1)];
      a  = 8'($urandom_range(0, 255));
      b  = 8'($urandom_range(0, 255));
      if (t == 0) begin a = 8'd5; b = 8'd9; op = 3'd1; end   // SUB with borrow
      bus_write(A_OPD1, 32'(a));
      bus_write(A_OPD2, 32'(b));
      bus_write(A_CTRL, {28'd0, op, 1'b1});
      r = model(op, a, b);
      exp_q.push_back(32'(r[7:0]));
      exp_q.push_back(32'(r[15:8]));
      wait_idle(n);
      checks++;
      if (n != ((op == 3'd6 || op == 3'd4) ? 8 : 1)) $display("FAIL rand_busy op %0d got %0d", op, n); else passes++;
      bus_read(A_RES_LO, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) $display("FAIL rand_res_lo op %0d a %0d b %0d got 0x%0h exp 0x%0h", op, a, b, got, exp); else passes++;
      bus_read(A_RES_HI, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) $display("FAIL rand_res_hi op %0d a %0d b %0d got 0x%0h exp 0x%0h", op, a, b, got, exp); else passes++;
      if (op == 3'd4 && b == 8'd0) bus_write(A_STATUS, 32'h4);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] got, exp;
    logic [3:0]  ra [7];
    bus_write(A_OPD1, 32'd255);
    bus_write(A_OPD2, 32'd255);
    bus_write(A_CTRL, 32'h1D);
    exp_q.push_back(32'd255);
    bus_read(A_OPD1, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) $display("FAIL midop_pre_reset got 0x%0h exp 0x%0h", got, exp); else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (data_o !== 32'd0) $display("FAIL midop_reset_data_o got 0x%0h exp 0x0", data_o); else passes++;
    checks++;
    if (irq_o !== 1'b0) $display("FAIL midop_reset_irq got %0b exp 0", irq_o); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    ra = '{A_STATUS, A_RES_LO, A_RES_HI, A_OPD1, A_CTRL, 4'd6, 4'd15};
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(32'd0);
      bus_read(ra[i], got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) $display("FAIL midop_after_reset addr %0d got 0x%0h exp 0x%0h", ra[i], got, exp); else passes++;
    end
  endtask

  // ---------------------------------------------------------- sequence
  initial begin
    test_reset();
    test_add();
    test_mul();
    test_busy_err();
    test_illegal_op();
    test_div();
    test_irq();
    test_scratch();
    test_random_ops();
    test_reset_mid_op();
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL scoreboard_leftover got %0d entries exp 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Hard stop if something stalls the sequence.
  initial begin
    #200000;
    $display("FAIL timeout got no finish exp finish by 200000");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1, "timeout");
  end

endmodule
